// File: rtl/traffic_light.sv
// rtl/traffic_light.sv - four-phase intersection controller with per-phase cycle timer
// Moore FSM: NS_GO -> NS_CLEAR -> EW_GO -> EW_CLEAR, each held for its parameterised length.
module traffic_light #(
  parameter int unsigned NS_GREEN_CYCLES = 20,
  parameter int unsigned EW_GREEN_CYCLES = 20,
  parameter int unsigned ALL_RED_CYCLES  = 3
) (
  input  logic clk,
  input  logic reset,
  output logic NS_red,
  output logic NS_green,
  output logic EW_red,
  output logic EW_green
);

  localparam int unsigned MAX_NE  = (NS_GREEN_CYCLES > EW_GREEN_CYCLES) ? NS_GREEN_CYCLES
                                                                        : EW_GREEN_CYCLES;
  localparam int unsigned MAX_LEN = (MAX_NE > ALL_RED_CYCLES) ? MAX_NE : ALL_RED_CYCLES;
  localparam int unsigned TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] NS_LAST  = TW'(NS_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] EW_LAST  = TW'(EW_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] RED_LAST = TW'(ALL_RED_CYCLES - 1);

  typedef enum logic [1:0] {
    NS_GO    = 2'd0,
    NS_CLEAR = 2'd1,
    EW_GO    = 2'd2,
    EW_CLEAR = 2'd3
  } state_e;

  state_e        state_q, state_d;
  state_e        next_phase;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] last_cnt;
  logic          ns_green_q, ew_green_q;

  always_comb begin
    last_cnt   = RED_LAST;
    next_phase = NS_GO;
    case (state_q)
      NS_GO: begin
        last_cnt   = NS_LAST;
        next_phase = NS_CLEAR;
      end
      NS_CLEAR: begin
        last_cnt   = RED_LAST;
        next_phase = EW_GO;
      end
      EW_GO: begin
        last_cnt   = EW_LAST;
        next_phase = EW_CLEAR;
      end
      default: begin
        last_cnt   = RED_LAST;
        next_phase = NS_GO;
      end
    endcase

    state_d = state_q;
    timer_d = timer_q + 1'b1;
    if (timer_q == last_cnt) begin
      state_d = next_phase;
      timer_d = '0;
    end
  end

  // Lamp registers are loaded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EW_CLEAR;
      timer_q    <= '0;
      ns_green_q <= 1'b0;
      ew_green_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ns_green_q <= (state_d == NS_GO);
      ew_green_q <= (state_d == EW_GO);
    end
  end

  // Reds are the complement of greens, so a red/green pair can never disagree.
  assign NS_green = ns_green_q;
  assign EW_green = ew_green_q;
  assign NS_red   = ~ns_green_q;
  assign EW_red   = ~ew_green_q;

endmodule

// File: tb/tb_traffic_light.sv
// tb/tb_traffic_light.sv - scoreboard bench for traffic_light, default and short-phase builds
module tb_traffic_light;

  localparam logic [3:0] RED = 4'b1010;
  localparam logic [3:0] NSG = 4'b0110;
  localparam logic [3:0] EWG = 4'b1001;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic ns_red_a, ns_green_a, ew_red_a, ew_green_a;
  logic ns_red_b, ns_green_b, ew_red_b, ew_green_b;
  logic [3:0] out_a, out_b;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  assign out_a = {ns_red_a, ns_green_a, ew_red_a, ew_green_a};
  assign out_b = {ns_red_b, ns_green_b, ew_red_b, ew_green_b};

  always #5 clk = ~clk;

  traffic_light dut_a (
    .clk      (clk),
    .reset    (reset),
    .NS_red   (ns_red_a),
    .NS_green (ns_green_a),
    .EW_red   (ew_red_a),
    .EW_green (ew_green_a)
  );

  traffic_light #(
    .NS_GREEN_CYCLES (1),
    .EW_GREEN_CYCLES (2),
    .ALL_RED_CYCLES  (1)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .NS_red   (ns_red_b),
    .NS_green (ns_green_b),
    .EW_red   (ew_red_b),
    .EW_green (ew_green_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle i counts rising edges since reset release; cycle 0 is the interval before the first edge.
  function automatic logic [3:0] expected_at(input int i, input int n, input int e, input int a);
    int p;
    p = i % (n + e + 2 * a);
    if (p < a)              return RED;
    else if (p < a + n)     return NSG;
    else if (p < 2 * a + n) return RED;
    else if (p < 2 * a + n + e) return EWG;
    else                    return RED;
  endfunction

  task automatic pop_compare();
    if (q_a.size() == 0) check("sb_a_empty", 0, 1);
    else                 check("sb_a", {28'd0, out_a}, {28'd0, q_a.pop_front()});
    if (q_b.size() == 0) check("sb_b_empty", 0, 1);
    else                 check("sb_b", {28'd0, out_b}, {28'd0, q_b.pop_front()});
  endtask

  // Called right after releasing reset; pushes the expected lamp pattern, then drains it cycle by cycle.
  task automatic run(input int cycles);
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < cycles; i++) begin
      q_a.push_back(expected_at(i, 20, 20, 3));
      q_b.push_back(expected_at(i, 1, 2, 1));
    end
    for (int i = 0; i < cycles; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      pop_compare();
    end
    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_ns_a", {31'd0, ns_red_a}, {31'd0, !ns_green_a});
      check("inv_ew_a", {31'd0, ew_red_a}, {31'd0, !ew_green_a});
      check("excl_a",   {31'd0, ns_green_a & ew_green_a}, 0);
      check("inv_ns_b", {31'd0, ns_red_b}, {31'd0, !ns_green_b});
      check("inv_ew_b", {31'd0, ew_red_b}, {31'd0, !ew_green_b});
      check("excl_b",   {31'd0, ns_green_b & ew_green_b}, 0);
    end
  end

  initial begin
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    mon_en = 1'b1;
    check("rst_async_a", {28'd0, out_a}, {28'd0, RED});
    check("rst_async_b", {28'd0, out_b}, {28'd0, RED});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_hold_a", {28'd0, out_a}, {28'd0, RED});
      check("rst_hold_b", {28'd0, out_b}, {28'd0, RED});
    end

    @(negedge clk);
    reset = 1'b1;
    run(130);

    check("pre_abort_ew_a", {28'd0, out_a}, {28'd0, EWG});
    reset = 1'b0;
    #1;
    check("abort_async_a", {28'd0, out_a}, {28'd0, RED});
    check("abort_async_b", {28'd0, out_b}, {28'd0, RED});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("abort_hold_a", {28'd0, out_a}, {28'd0, RED});
      check("abort_hold_b", {28'd0, out_b}, {28'd0, RED});
    end

    @(negedge clk);
    reset = 1'b1;
    run(60);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
